// File: rtl/cordic_cos_sequencer.sv
// cordic_cos_sequencer: float angle -> Q0.F theta, runs one CORDIC cosine job, repacks Q1.31 result to float
module cordic_cos_sequencer #(
  parameter int          FRACTIONAL_BITS = 31,
  parameter int          TIMEOUT         = 64,
  parameter logic [31:0] NAN_VALUE       = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        cordic_start,
  output logic [31:0] cordic_theta,
  input  logic        cordic_done,
  input  logic [31:0] cordic_cos
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, UNPACK, ISSUE, WAIT, NORM, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, result_q, result_d, theta_q, theta_d, m_q, m_d;
  logic [7:0] exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, cs_q, cs_d;
  logic [31:0] mag, ext;
  logic [7:0] e, sh;
  // cos is even, so the sign bit is masked off before unpacking
  assign mag = a_q & 32'h7FFF_FFFF;
  assign e = mag[30:23];
  assign sh = 8'd127 - e;
  assign ext = {8'b0, 1'b1, mag[22:0]} << (FRACTIONAL_BITS - 23);
  assign done = done_q;
  assign result = result_q;
  assign cordic_start = cs_q;
  assign cordic_theta = theta_q;
  // next-state and registered-output logic for the job sequence
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    result_d = result_q;
    theta_d = theta_q;
    m_d = m_q;
    exp_d = exp_q;
    cnt_d = cnt_q;
    cs_d = 1'b0;
    done_d = state_q == DONE;
    case (state_q)
      IDLE: if (start) begin
        a_d = dataa;
        state_d = UNPACK;
      end
      UNPACK: if (e >= 8'd127) begin
        result_d = NAN_VALUE;
        state_d = DONE;
      end else begin
        theta_d = (e <= 8'(127 - FRACTIONAL_BITS)) ? 32'd0 : ext >> sh;
        state_d = ISSUE;
      end
      ISSUE: begin
        cs_d = 1'b1;
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (cordic_done) begin
        m_d = cordic_cos;
        exp_d = 8'd127;
        state_d = NORM;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        result_d = NAN_VALUE;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      NORM: if (m_q[31] || m_q == 32'd0) begin
        result_d = m_q[31] ? {1'b0, exp_q, m_q[30:8]} : 32'd0;
        state_d = DONE;
      end else begin
        m_d = m_q << 1;
        exp_d = exp_q - 8'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state register; clk_en gates every update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      result_q <= '0;
      theta_q <= '0;
      m_q <= '0;
      exp_q <= '0;
      cnt_q <= '0;
      cs_q <= 1'b0;
      done_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      a_q <= a_d;
      result_q <= result_d;
      theta_q <= theta_d;
      m_q <= m_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;
      cs_q <= cs_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_cordic_cos_sequencer.sv
// tb_cordic_cos_sequencer: random and directed jobs against a float-level reference model with a mock core
module tb_cordic_cos_sequencer;
  localparam int F = 31;
  localparam logic [31:0] NAN = 32'h7FC00000;
  logic clk = 1'b0, reset, clk_en, start, cordic_done, done, cordic_start;
  logic [31:0] dataa, cordic_cos, result, cordic_theta;
  int total = 0, bad = 0;
  cordic_cos_sequencer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
    .done(done), .result(result), .cordic_start(cordic_start), .cordic_theta(cordic_theta),
    .cordic_done(cordic_done), .cordic_cos(cordic_cos)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_theta(input logic [31:0] a);
    int e = int'(a[30:23]);
    real r;
    if (e > 126 || e <= 127 - F) return 32'd0;
    r = (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return 32'(longint'($floor(r * (2.0 ** F))));
  endfunction
  function automatic int msb(input logic [31:0] c);
    for (int i = 31; i >= 0; i--) if (c[i]) return i;
    return -1;
  endfunction
  function automatic logic [31:0] ref_result(input logic [31:0] c);
    int p = msb(c);
    logic [31:0] f;
    if (p < 0) return 32'd0;
    f = c << (31 - p);
    return {1'b0, 8'(127 - (31 - p)), f[30:8]};
  endfunction
  task automatic run_job(input logic [31:0] a, input logic [31:0] c, input int d, input bit never, input int en_mode);
    bit oor = a[30:23] >= 8'd127;
    logic [31:0] exp_theta = ref_theta(a);
    logic [31:0] exp_res = (oor || never) ? NAN : ref_result(c);
    int exp_lat = oor ? 2 : never ? 67 : 4 + d + (msb(c) < 0 ? 1 : 32 - msb(c));
    int en_edges = 0, n = 0, cd = -1, pulses = 0;
    bit prev_cs, prev_en, got = 0;
    logic [31:0] s_res, s_th;
    logic [1:0] s_ctl;
    dataa = a;
    cordic_cos = c;
    start = 1'b1;
    clk_en = 1'b1;
    cordic_done = 1'b0;
    while (!got && n < 400) begin
      prev_en = clk_en;
      prev_cs = cordic_start;
      s_res = result;
      s_th = cordic_theta;
      s_ctl = {done, cordic_start};
      @(posedge clk);
      #1;
      n++;
      if (!prev_en) begin
        chk("frz_res", result, s_res);
        chk("frz_theta", cordic_theta, s_th);
        chk("frz_ctl", {30'd0, done, cordic_start}, {30'd0, s_ctl});
      end else begin
        en_edges++;
        start = 1'b0;
        cordic_done = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) cordic_done = 1'b1;
        end
        if (prev_cs) begin
          pulses++;
          chk("theta", cordic_theta, exp_theta);
          if (!never) begin
            cd = d - 1;
            if (cd == 0) cordic_done = 1'b1;
          end
        end
        if (done) begin
          got = 1'b1;
          chk("latency", 32'(en_edges - 1), 32'(exp_lat));
          chk("result", result, exp_res);
        end
      end
      if (got || cordic_done || en_mode == 0) clk_en = 1'b1;
      else if (en_mode == 1) clk_en = $urandom_range(3) != 0;
      else clk_en = !(en_edges == 3 && (n - en_edges) < 5);
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("cs_pulses", 32'(pulses), oor ? 32'd0 : 32'd1);
    if (en_mode == 2) chk("frz_total", 32'(n - 1), 32'(exp_lat + 5));
    @(posedge clk);
    #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("res_hold", result, exp_res);
  endtask
  initial begin
    reset = 1'b1;
    clk_en = 1'b1;
    start = 1'b0;
    dataa = '0;
    cordic_done = 1'b0;
    cordic_cos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_cs", {31'd0, cordic_start}, 32'd0);
    chk("rst_theta", cordic_theta, 32'd0);
    reset = 1'b0;
    run_job(32'h3F000000, 32'h80000000, 1, 0, 0);
    run_job(32'hBF000000, 32'h60000000, 1, 0, 0);
    run_job(32'h3F800000, 32'h80000000, 1, 0, 0);
    run_job(32'h7F800000, 32'h80000000, 1, 0, 0);
    run_job(32'h2F800000, 32'h00000001, 1, 0, 0);
    run_job(32'h00000000, 32'h00000001, 1, 0, 0);
    run_job(32'h3E800000, 32'h12345678, 1, 1, 0);
    run_job(32'h3F000000, 32'h80000000, 1, 0, 0);
    run_job(32'h3F000000, 32'h80000000, 3, 0, 2);
    dataa = 32'h3F000000;
    cordic_cos = 32'h00000001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cordic_done = 1'b1;
    @(posedge clk);
    #1;
    cordic_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_res", result, 32'd0);
    chk("arst_theta", cordic_theta, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_idle", {31'd0, done}, 32'd0);
    run_job(32'h3F000000, 32'h60000000, 2, 0, 0);
    for (int j = 0; j < 40; j++) begin
      int k = $urandom_range(9);
      logic [7:0] e = k == 0 ? 8'($urandom_range(255, 127)) : k == 1 ? 8'($urandom_range(96)) : 8'($urandom_range(126, 97));
      logic [31:0] a = {1'($urandom), e, 23'($urandom)};
      logic [31:0] c = $urandom_range(7) == 0 ? 32'd0 : $urandom >> $urandom_range(31);
      run_job(a, c, $urandom_range(6, 1), $urandom_range(15) == 0, $urandom_range(1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_cos_sequencer.md
Name: cordic_cos_sequencer

Overview:
- Multi-cycle custom-instruction front end for the iterative CORDIC cosine core.
- Takes an IEEE-754 single-precision angle and converts it to unsigned Q0.31 magnitude. Conversion matches the float-to-fixed unpack rule, with the sign dropped because cos is even.
- Issues one job to the core, waits for its result and repacks the Q1.31 result to single precision.
- Sits between the processor custom-instruction port and the core; it owns the core's start/done handshake.

Parameters:
- FRACTIONAL_BITS, 31, fractional bits of the angle given to the core (Q0.FRACTIONAL_BITS, 24..31).
- TIMEOUT, 64, maximum WAIT cycles before the job is abandoned.
- NAN_VALUE, 32'h7FC00000, result word for out-of-range input or timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  one-cycle request, sampled only in IDLE with clk_en=1.
- dataa  in  32  angle in radians, IEEE-754 single.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  32  cos(dataa), IEEE-754 single.
- cordic_start  out  1  one-cycle pulse to the core.
- cordic_theta  out  32  unsigned Q0.FRACTIONAL_BITS angle, held stable from ISSUE until the core reports done.
- cordic_done  in  1  core result-valid pulse.
- cordic_cos  in  32  unsigned Q1.31 cosine, valid when cordic_done=1.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. done=0, result=0, cordic_start=0, cordic_theta=0, all counters=0.
- clk_en=0: no state, register or output changes. A cordic_done arriving while clk_en=0 is lost; the system guarantees this does not occur.
- States: IDLE, UNPACK, ISSUE, WAIT, NORM, DONE.
- IDLE: when start=1, register dataa and go to UNPACK. start in any other state is ignored.
- UNPACK (1 cycle), with E = dataa[30:23]:
  - E >= 127 (|x| >= 1, Inf or NaN): load NAN_VALUE into result and go to DONE. The core is not started.
  - dataa[30:0]=0, or E <= 127-FRACTIONAL_BITS: theta=0.
  - Otherwise theta = {1, dataa[22:0], (FRACTIONAL_BITS-23) zeros}, zero-extended to 32 bits, logically shifted right by (127-E).
  - The sign bit is ignored in all cases. Go to ISSUE.
- ISSUE (1 cycle): cordic_start=1 and cordic_theta=theta. Clear the timeout counter. Go to WAIT.
- WAIT:
  - cordic_done=1: capture cordic_cos into the mantissa register and set exp=127. Go to NORM.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without done, load NAN_VALUE into result and go to DONE.
  - A cordic_done arriving in the same cycle the timeout fires is taken as done; done wins.
- NORM (one cycle per step):
  - If m[31]=1: result = {0, exp[7:0], m[30:8]} (truncate) and go to DONE.
  - Else if m=0: result=0 and go to DONE.
  - Else m <<= 1, exp -= 1 and stay in NORM. This takes at most 31 steps, and exp never underflows since exp >= 96.
- DONE (1 cycle): done=1 and result is held. Go to IDLE.
- After DONE, result holds its value until the next job writes it. done is registered.
- Latency from the start edge:
  - Normal path: done asserts 4 + W + S cycles later, where W = WAIT cycles including the done cycle and S = NORM cycles (>= 1).
  - Out-of-range path: done asserts exactly 2 cycles later.
- cordic_done seen outside WAIT is ignored.

Test Plan:
- dataa=0x3F000000 (0.5); mock core returns cordic_cos=0x80000000 one cycle after cordic_start → cordic_theta=0x40000000, one cordic_start pulse, result=0x3F800000, done at start+6.
- dataa=0xBF000000 (-0.5); core returns 0x60000000 (0.75) → cordic_theta=0x40000000 (sign dropped), 2 NORM cycles, result=0x3F400000.
- Boundary inputs:
  - dataa=0x3F800000 (1.0) → no cordic_start; done at start+2 with result=0x7FC00000.
  - dataa=0x7F800000 (Inf) → same response.
- Small and zero inputs: dataa=0x2F800000 (E=95) and dataa=0x00000000 → cordic_theta=0. Core returns 0x00000001 → result=0x30000000 after 32 NORM cycles.
- Timeout: core never asserts cordic_done, TIMEOUT=64 → done with result=0x7FC00000 exactly 64 WAIT cycles after ISSUE. A second start then behaves normally.
- Control: clk_en low for 5 cycles during WAIT → state and outputs frozen, latency extended by 5. Reset pulsed mid-NORM → immediate IDLE, done=0, result=0, and a start two cycles later completes correctly.
